// File: rtl/mem_arb_pkg.sv
// mem_arbiter shared types: FSM states, owner encoding, latency bound.
// Imported by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_EXT = 1'b1
    } owner_t;

    localparam int LAT_MAX = 3;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the CPU and external ports.
// MEM_ARB_RR_EN: round-robin on collisions; otherwise CPU has priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   ext_req,
    input  owner_t last,
    output logic   win,
    output owner_t who
);

`ifdef MEM_ARB_RR_EN
    // On a collision the port that did not own memory last time wins
    always_comb begin
        win = cpu_req | ext_req;
        who = OWN_CPU;
        if (cpu_req && ext_req)
            who = (last == OWN_CPU) ? OWN_EXT : OWN_CPU;
        else if (ext_req)
            who = OWN_EXT;
    end
`else
    logic unused_last;
    assign unused_last = last;

    // Fixed priority: CPU beats the external port
    always_comb begin
        win = cpu_req | ext_req;
        who = (!cpu_req && ext_req) ? OWN_EXT : OWN_CPU;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU vs external loader, fixed-latency access.
// Arbitration policy selected by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW  = 5,
    parameter int DW  = 8,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_done,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_done,
    output logic [DW-1:0] rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0] WAIT_LOAD = 2'(LAT - 2);

    arb_state_t state;
    owner_t     owner;
    owner_t     last;
    owner_t     who;
    logic       win;
    logic       we_q;
    logic [1:0] cnt;

    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    mem_arb_pick u_pick (
        .cpu_req (cpu_req),
        .ext_req (ext_req),
        .last    (last),
        .win     (win),
        .who     (who)
    );

    // Route the winning port's request fields toward the latch
    always_comb begin
        sel_we    = (who == OWN_EXT) ? ext_we    : cpu_we;
        sel_addr  = (who == OWN_EXT) ? ext_addr  : cpu_addr;
        sel_wdata = (who == OWN_EXT) ? ext_wdata : cpu_wdata;
    end

    // Read data is exposed only during a read's done cycle
    assign rdata = (state == DONE && !we_q) ? mem_rdata : '0;

    // Access sequencer with registered grants, strobes and done pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_CPU;
            last      <= OWN_EXT;
            we_q      <= 1'b0;
            cnt       <= '0;
            cpu_gnt   <= 1'b0;
            ext_gnt   <= 1'b0;
            cpu_done  <= 1'b0;
            ext_done  <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win) begin
                        state     <= ACCESS;
                        owner     <= who;
                        last      <= who;
                        we_q      <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_rd    <= !sel_we;
                        mem_wr    <= sel_we;
                        cpu_gnt   <= (who == OWN_CPU);
                        ext_gnt   <= (who == OWN_EXT);
                        busy      <= 1'b1;
                    end
                end
                ACCESS: begin
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    if (we_q || LAT == 1) begin
                        state    <= DONE;
                        cpu_done <= (owner == OWN_CPU);
                        ext_done <= (owner == OWN_EXT);
                    end else begin
                        state <= WAIT;
                        cnt   <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state    <= DONE;
                        cpu_done <= (owner == OWN_CPU);
                        ext_done <= (owner == OWN_EXT);
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cpu_gnt  <= 1'b0;
                    ext_gnt  <= 1'b0;
                    cpu_done <= 1'b0;
                    ext_done <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a LAT=1 and a LAT=3 instance.
// Done responses are queued at issue and checked by per-instance monitors.
module tb_mem_arbiter;

    typedef struct {
        bit         own;
        bit         we;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    exp_t q1[$];
    exp_t q3[$];

    // LAT=1 instance signals
    logic       cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
    logic [4:0] cpu_addr = 0, ext_addr = 0;
    logic [7:0] cpu_wdata = 0, ext_wdata = 0;
    logic       cpu_gnt, cpu_done, ext_gnt, ext_done;
    logic       mem_rd, mem_wr, busy;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, rdata, mem_rdata;

    // LAT=3 instance signals (CPU port only is exercised)
    logic       r3_req = 0, r3_we = 0;
    logic [4:0] r3_addr = 0;
    logic [7:0] r3_wdata = 0;
    logic       x3_req = 0, x3_we = 0;
    logic [4:0] x3_addr = 0;
    logic [7:0] x3_wdata = 0;
    logic       g3_cpu, d3_cpu, g3_ext, d3_ext;
    logic       rd3, wr3, busy3;
    logic [4:0] addr3;
    logic [7:0] wdata3, rdata3, mrdata3;

    mem_arbiter #(.AW(5), .DW(8), .LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_gnt(ext_gnt), .ext_done(ext_done),
        .rdata(rdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.AW(5), .DW(8), .LAT(3)) u3 (
        .clk(clk), .rst(rst),
        .cpu_req(r3_req), .cpu_we(r3_we),
        .cpu_addr(r3_addr), .cpu_wdata(r3_wdata),
        .cpu_gnt(g3_cpu), .cpu_done(d3_cpu),
        .ext_req(x3_req), .ext_we(x3_we),
        .ext_addr(x3_addr), .ext_wdata(x3_wdata),
        .ext_gnt(g3_ext), .ext_done(d3_ext),
        .rdata(rdata3), .mem_rd(rd3), .mem_wr(wr3),
        .mem_addr(addr3), .mem_wdata(wdata3),
        .mem_rdata(mrdata3), .busy(busy3)
    );

    // Memory models: 1-cycle and 3-cycle read pipelines
    logic [7:0] mem1 [32];
    logic [7:0] mem3 [32];
    logic [7:0] rq1 = 0, s1 = 0, s2 = 0, s3 = 0;
    assign mem_rdata = rq1;
    assign mrdata3   = s3;

    always @(posedge clk) begin
        if (mem_wr) mem1[mem_addr] = mem_wdata;
        if (mem_rd) rq1 <= mem1[mem_addr];
        if (rd3) s1 <= mem3[addr3];
        s2 <= s1;
        s3 <= s2;
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor for the LAT=1 instance
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("u1 one gnt", int'(cpu_gnt & ext_gnt), 0);
            chk("u1 one strobe", int'(mem_rd & mem_wr), 0);
            if (cpu_done || ext_done) begin
                if (q1.size() == 0) begin
                    chk("u1 unexpected done", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("u1 owner", int'(ext_done), int'(e.own));
                    chk("u1 one done", int'(cpu_done & ext_done), 0);
                    if (!e.we) chk("u1 rdata", int'(rdata), int'(e.data));
                end
            end
        end
    end

    // Monitor for the LAT=3 instance
    always @(negedge clk) begin
        exp_t e;
        if (rst && (d3_cpu || d3_ext)) begin
            if (q3.size() == 0) begin
                chk("u3 unexpected done", 1, 0);
            end else begin
                e = q3.pop_front();
                chk("u3 owner", int'(d3_ext), int'(e.own));
                if (!e.we) chk("u3 rdata", int'(rdata3), int'(e.data));
            end
        end
    end

    task automatic wait_done3(input string nm);
        bit ok = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (d3_cpu) begin ok = 1; break; end
        end
        r3_req = 0;
        chk(nm, int'(ok), 1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit ok;
        logic [4:0] t_rd, t_busy, t_done;
        for (int i = 0; i < 32; i++) begin
            mem1[i] = 8'h00;
            mem3[i] = 8'h00;
        end
        mem1[5] = 8'h3C;
        mem1[3] = 8'h33;
        mem1[9] = 8'h99;
        mem3[7] = 8'h7E;
        mem3[2] = 8'h2D;

        // Reset state
        #12;
        chk("rst busy", int'(busy), 0);
        chk("rst gnt", int'({cpu_gnt, ext_gnt}), 0);
        chk("rst strobes", int'({mem_rd, mem_wr}), 0);
        chk("rst done", int'({cpu_done, ext_done}), 0);
        chk("rst addr", int'(mem_addr), 0);
        chk("rst wdata", int'(mem_wdata), 0);
        chk("rst rdata", int'(rdata), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);

        // CPU read of addr 5, LAT=1
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'd5;
        q1.push_back('{1'b0, 1'b0, 8'h3C});
        @(negedge clk);
        chk("rd access mem_rd", int'(mem_rd), 1);
        chk("rd access gnt", int'({cpu_gnt, ext_gnt}), 2);
        chk("rd access addr", int'(mem_addr), 5);
        chk("rd access busy", int'(busy), 1);
        @(negedge clk);
        chk("rd done mem_rd", int'(mem_rd), 0);
        chk("rd done pulse", int'(cpu_done), 1);
        chk("rd done ext_gnt", int'(ext_gnt), 0);
        cpu_req = 0;
        @(negedge clk);
        chk("rd idle busy", int'(busy), 0);
        chk("rd idle done", int'(cpu_done), 0);

        // External write of 0xA5 to addr 12
        ext_req = 1; ext_we = 1; ext_addr = 5'd12; ext_wdata = 8'hA5;
        q1.push_back('{1'b1, 1'b1, 8'h00});
        @(negedge clk);
        chk("wr access mem_wr", int'({mem_rd, mem_wr}), 1);
        chk("wr access addr", int'(mem_addr), 12);
        chk("wr access wdata", int'(mem_wdata), 8'hA5);
        chk("wr access gnt", int'({cpu_gnt, ext_gnt}), 1);
        @(negedge clk);
        chk("wr done mem_wr", int'(mem_wr), 0);
        chk("wr done pulse", int'(ext_done), 1);
        ext_req = 0; ext_we = 0;
        @(negedge clk);
        chk("wr idle busy", int'(busy), 0);

        // Both ports held for four transactions
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'd3;
        ext_req = 1; ext_we = 0; ext_addr = 5'd9;
`ifdef MEM_ARB_RR_EN
        q1.push_back('{1'b0, 1'b0, 8'h33});
        q1.push_back('{1'b1, 1'b0, 8'h99});
        q1.push_back('{1'b0, 1'b0, 8'h33});
        q1.push_back('{1'b1, 1'b0, 8'h99});
`else
        for (int i = 0; i < 4; i++)
            q1.push_back('{1'b0, 1'b0, 8'h33});
`endif
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cpu_done || ext_done) n++;
            if (n == 4) break;
        end
        cpu_req = 0; ext_req = 0;
        chk("arb 4 txns", n, 4);
        @(negedge clk);

        // CPU drops req during ACCESS; read back the written byte
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'd12;
        q1.push_back('{1'b0, 1'b0, 8'hA5});
        @(negedge clk);
        chk("drop access gnt", int'(cpu_gnt), 1);
        cpu_req = 0;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cpu_done) begin ok = 1; break; end
        end
        chk("drop still done", int'(ok), 1);
        @(negedge clk);

        // LAT=3 read: ACCESS, WAIT, WAIT, DONE, IDLE
        t_rd   = 5'b00001;
        t_busy = 5'b01111;
        t_done = 5'b01000;
        r3_req = 1; r3_we = 0; r3_addr = 5'd7;
        q3.push_back('{1'b0, 1'b0, 8'h7E});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("lat3 mem_rd c%0d", i), int'(rd3), int'(t_rd[i]));
            chk($sformatf("lat3 busy c%0d", i), int'(busy3), int'(t_busy[i]));
            chk($sformatf("lat3 done c%0d", i), int'(d3_cpu), int'(t_done[i]));
            if (d3_cpu) r3_req = 0;
        end
        r3_req = 0;

        // Reset asserted during WAIT loses the transaction
        r3_req = 1; r3_addr = 5'd7;
        @(negedge clk);
        chk("rstw access rd", int'(rd3), 1);
        @(negedge clk);
        chk("rstw in wait", int'(busy3 & ~rd3 & ~d3_cpu), 1);
        #2 rst = 0;
        r3_req = 0;
        #1;
        chk("rstw mem_rd", int'(rd3), 0);
        chk("rstw gnt", int'(g3_cpu), 0);
        chk("rstw busy", int'(busy3), 0);
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstw no done", int'(d3_cpu), 0);
        end

        // Normal service after reset release
        r3_req = 1; r3_addr = 5'd2;
        q3.push_back('{1'b0, 1'b0, 8'h2D});
        wait_done3("lat3 post-rst done");

        chk("q1 drained", q1.size(), 0);
        chk("q3 drained", q3.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
